memory_access: RTL and testbench
================================

# memory_access

Memory stage of the five-stage pipeline. Consumes the execute stage's M-side pipeline register outputs (control, ALU result, store data, destination register), drives a variable-latency word-wide data-memory bus with a request/ready handshake, stalls the pipeline while an access is outstanding, and registers the writeback-stage pipeline values. It also produces the writeback result `result_w_o`, which feeds back to the execute-stage forwarding muxes.

## Interface
- `TIMEOUT`, default 255: maximum number of WAIT cycles before an access is abandoned. Legal range is 1..255.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data substituted when a load is abandoned.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `reg_write_m_i` input 1: M-stage instruction writes the register file.
- `mem_write_m_i` input 1: M-stage instruction is a store.
- `mem_to_reg_m_i` input 1: M-stage instruction is a load.
- `alu_out_m_i` input 32: ALU result; this is the memory address for loads and stores.
- `write_data_m_i` input 32: store data.
- `write_reg_m_i` input 5: destination register.
- `mem_req_o` output 1: bus request.
- `mem_we_o` output 1: write enable (1 = store).
- `mem_addr_o` output 32: byte address, word-aligned.
- `mem_wdata_o` output 32: store data.
- `mem_ready_i` input 1: memory completes the current request this cycle.
- `mem_rdata_i` input 32: load data, valid when `mem_ready_i` = 1.
- `stall_m_o` output 1: hold PC and the F/D/E/M registers this cycle.
- `reg_write_w_o`, `mem_to_reg_w_o` output 1 each: W-stage control.
- `read_data_w_o`, `alu_out_w_o` output 32 each: W-stage data.
- `write_reg_w_o` output 5: W-stage destination register.
- `result_w_o` output 32: `mem_to_reg_w_o ? read_data_w_o : alu_out_w_o`.
- `bus_error_o` output 1: sticky; set on a timeout or a misaligned access.

## Operation
- `access = mem_write_m_i | mem_to_reg_m_i`. A bubble has all control bits at 0, so it never accesses memory.
- `misaligned = access & (alu_out_m_i[1:0] != 0)`. When `misaligned` = 1:
  - no request is issued (`mem_req_o` = 0) and there is no stall;
  - `bus_error_o` is set at the next edge;
  - W receives the instruction with `reg_write_w_o` forced to 0.
- `mem_addr_o = alu_out_m_i`, `mem_wdata_o = write_data_m_i`, `mem_we_o = mem_write_m_i`. These are combinational and are held stable while stalled, because the M inputs are frozen.
- `mem_req_o = access & ~misaligned & ~abandon`. `abandon` is 1 in WAIT when the count reaches `TIMEOUT`.
- `stall_m_o = mem_req_o & ~mem_ready_i`.

FSM, two states:
- IDLE: if `mem_req_o & ~mem_ready_i`, go to WAIT with `cnt` = 1. Otherwise stay in IDLE.
- WAIT: if `mem_ready_i`, go to IDLE. Else if `cnt == TIMEOUT`, set `abandon` = 1 this cycle, go to IDLE and set `bus_error_o`. Otherwise increment `cnt`.
- `cnt` is 8 bits wide, saturates at `TIMEOUT` and is cleared on entering IDLE.

W register update, every edge:
- If `stall_m_o` = 1: load a bubble (all W outputs 0). The previous W instruction retires normally.
- Else: load the M instruction.
  - `read_data_w_o` gets `mem_rdata_i` on a normal completion, or `ERR_DATA` on an abandoned load. For a store or non-memory instruction its value is don't-care, but it must be deterministic: 0.
  - `reg_write_w_o` gets `reg_write_m_i & ~misaligned & ~abandon`.
- A store completes when `mem_ready_i` is seen. No write is retried after abandon.

Reset (`rst_i` = 0, asynchronous):
- The FSM goes to IDLE, `cnt` = 0 and `bus_error_o` = 0.
- All W outputs are 0, so `result_w_o` = 0.
- `mem_req_o` and `stall_m_o` remain combinational from the inputs; the bench drives the M inputs to 0 during reset.
- Reset in the middle of a WAIT drops the access. The memory is expected to ignore a deasserted request.

## Timing
- Zero-wait access (`mem_ready_i` = 1 in the same cycle as `mem_req_o`): no stall, and the W register is valid 1 cycle later.
- N-wait access: `stall_m_o` is high for exactly N cycles. W is loaded at the edge of the cycle in which `mem_ready_i` = 1, and `stall_m_o` drops combinationally in that cycle.
- Abandon: `stall_m_o` is high for `TIMEOUT` cycles. In the next cycle (cnt == `TIMEOUT`), `stall_m_o` = 0 and `mem_req_o` = 0. `bus_error_o` rises 1 edge later.
- Back-to-back accesses: a new request may be asserted in the cycle immediately after completion, with no idle cycle required.
- `mem_ready_i` while `mem_req_o` = 0 is ignored.
- `result_w_o` is purely combinational from the W register.

## Test plan
- Reset and bubble: assert `rst_i` = 0 in the middle of a cycle -> all outputs 0 immediately. After release, with M inputs = 0 -> `mem_req_o` = 0 and W stays 0.
- Zero-wait load: addr 0x40, `mem_ready_i` = 1, rdata 0x1234_5678, rd = 5 -> no stall. Next cycle `reg_write_w_o` = 1, `write_reg_w_o` = 5, `result_w_o` = 0x1234_5678.
- 3-wait store: addr 0x80, wdata 0xCAFE_F00D -> `stall_m_o` high for 3 cycles, with addr and wdata stable. W gets bubbles, then the store with `reg_write_w_o` = 0.
- Load followed immediately by ALU op: 2-wait load, then ALU op with alu_out 0x99, rd = 7 -> the ALU op reaches W 1 cycle after the load, with `result_w_o` = 0x99.
- Timeout: `TIMEOUT` = 4 and `mem_ready_i` held at 0 -> 4 stall cycles, then the request drops. W gets `read_data_w_o` = 0xDEAD_BEEF with `reg_write_w_o` = 0, and `bus_error_o` = 1 and stays set.
- Misaligned and reset during WAIT:
  - Load at addr 0x42 -> no request, no stall, `bus_error_o` = 1.
  - Separately, a reset during WAIT -> FSM goes to IDLE, and the next access starts from `cnt` = 1.

Source files
------------

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//
// Memory stage of the five-stage pipeline. Takes the M-side pipeline register
// values from execute, drives a variable-latency word-wide data bus with a
// request/ready handshake, stalls the pipeline while an access is outstanding,
// and registers the writeback-stage values.
//
// Handshake: mem_req_o is held high, with address, write data and write
// enable stable, until the cycle in which mem_ready_i is 1. That cycle
// completes the transfer. mem_ready_i has no effect while mem_req_o is 0.
// A request can also be withdrawn by the timeout (abandon).
//
// Parameters:
//   TIMEOUT  - maximum WAIT cycles before an access is abandoned (1..255)
//   ERR_DATA - read data substituted for an abandoned load
//
// Ports:
//   clk_i, rst_i                 clock, async active-low reset
//   reg_write_m_i .. write_reg_m_i  M-stage control and data from execute
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o   data-memory request
//   mem_ready_i, mem_rdata_i     data-memory response
//   stall_m_o                    hold PC and F/D/E/M registers
//   *_w_o                        W-stage pipeline register outputs
//   result_w_o                   writeback result (also forwarded to execute)
//   bus_error_o                  sticky: timeout or misaligned access seen
//   dbg_state_o, dbg_cnt_o       FSM state (1 = WAIT) and wait counter
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_write_m_i,
  input  logic        mem_write_m_i,
  input  logic        mem_to_reg_m_i,
  input  logic [31:0] alu_out_m_i,
  input  logic [31:0] write_data_m_i,
  input  logic [4:0]  write_reg_m_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_m_o,
  output logic        reg_write_w_o,
  output logic        mem_to_reg_w_o,
  output logic [31:0] read_data_w_o,
  output logic [31:0] alu_out_w_o,
  output logic [4:0]  write_reg_w_o,
  output logic [31:0] result_w_o,
  output logic        bus_error_o,
  output logic        dbg_state_o,
  output logic [7:0]  dbg_cnt_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        bus_error_q;

  logic        access;
  logic        misaligned;
  logic        abandon;
  logic        done;

  logic        reg_write_d,  reg_write_q;
  logic        mem_to_reg_d, mem_to_reg_q;
  logic [31:0] read_data_d,  read_data_q;
  logic [31:0] alu_out_d,    alu_out_q;
  logic [4:0]  write_reg_d,  write_reg_q;

  // ---------------------------------------------------------------------------
  // Request generation. The M inputs are frozen while stalled, so the bus
  // fields stay stable for the whole access without extra registers.
  // ---------------------------------------------------------------------------
  assign access     = mem_write_m_i | mem_to_reg_m_i;
  assign misaligned = access & (alu_out_m_i[1:0] != 2'b00);
  // The request is withdrawn in the final WAIT cycle, so a late ready in
  // that cycle is ignored and the access counts as abandoned.
  assign abandon    = (state_q == S_WAIT) && (cnt_q == TIMEOUT_C);

  assign mem_req_o   = access & ~misaligned & ~abandon;
  assign mem_we_o    = mem_write_m_i;
  assign mem_addr_o  = alu_out_m_i;
  assign mem_wdata_o = write_data_m_i;
  assign stall_m_o   = mem_req_o & ~mem_ready_i;
  assign done        = mem_req_o & mem_ready_i;

  // ---------------------------------------------------------------------------
  // Access FSM with wait counter and sticky bus error.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bus_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stall_m_o) begin
            state_q <= S_WAIT;
            cnt_q   <= 8'd1;
          end else begin
            cnt_q   <= 8'd0;
          end
        end
        S_WAIT: begin
          if (done || abandon) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
          end else if (cnt_q < TIMEOUT_C) begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
      if (misaligned || abandon) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // W register next state. A stalled cycle inserts a bubble; otherwise the M
  // instruction moves on. Read data is 0 unless a load completed or was
  // abandoned, so W contents are deterministic for stores and ALU ops.
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    read_data_d  = 32'd0;
    alu_out_d    = 32'd0;
    write_reg_d  = 5'd0;
    if (!stall_m_o) begin
      reg_write_d  = reg_write_m_i & ~misaligned & ~abandon;
      mem_to_reg_d = mem_to_reg_m_i;
      alu_out_d    = alu_out_m_i;
      write_reg_d  = write_reg_m_i;
      if (mem_to_reg_m_i && done) begin
        read_data_d = mem_rdata_i;
      end else if (mem_to_reg_m_i && abandon) begin
        read_data_d = ERR_DATA;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= 32'd0;
      alu_out_q    <= 32'd0;
      write_reg_q  <= 5'd0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      read_data_q  <= read_data_d;
      alu_out_q    <= alu_out_d;
      write_reg_q  <= write_reg_d;
    end
  end

  assign reg_write_w_o  = reg_write_q;
  assign mem_to_reg_w_o = mem_to_reg_q;
  assign read_data_w_o  = read_data_q;
  assign alu_out_w_o    = alu_out_q;
  assign write_reg_w_o  = write_reg_q;
  assign result_w_o     = mem_to_reg_q ? read_data_q : alu_out_q;
  assign bus_error_o    = bus_error_q;
  assign dbg_state_o    = state_q;
  assign dbg_cnt_o      = cnt_q;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//
// Directed-vector bench for memory_access (TIMEOUT = 4). Inputs change 1 ns
// after the rising edge; combinational outputs are sampled on the falling
// edge and W outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_memory_access;

  logic        clk_i;
  logic        rst_i;
  logic        reg_write_m_i;
  logic        mem_write_m_i;
  logic        mem_to_reg_m_i;
  logic [31:0] alu_out_m_i;
  logic [31:0] write_data_m_i;
  logic [4:0]  write_reg_m_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        stall_m_o;
  logic        reg_write_w_o;
  logic        mem_to_reg_w_o;
  logic [31:0] read_data_w_o;
  logic [31:0] alu_out_w_o;
  logic [4:0]  write_reg_w_o;
  logic [31:0] result_w_o;
  logic        bus_error_o;
  logic        dbg_state_o;
  logic [7:0]  dbg_cnt_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  memory_access #(
    .TIMEOUT  (4),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reg_write_m_i  (reg_write_m_i),
    .mem_write_m_i  (mem_write_m_i),
    .mem_to_reg_m_i (mem_to_reg_m_i),
    .alu_out_m_i    (alu_out_m_i),
    .write_data_m_i (write_data_m_i),
    .write_reg_m_i  (write_reg_m_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ready_i    (mem_ready_i),
    .mem_rdata_i    (mem_rdata_i),
    .stall_m_o      (stall_m_o),
    .reg_write_w_o  (reg_write_w_o),
    .mem_to_reg_w_o (mem_to_reg_w_o),
    .read_data_w_o  (read_data_w_o),
    .alu_out_w_o    (alu_out_w_o),
    .write_reg_w_o  (write_reg_w_o),
    .result_w_o     (result_w_o),
    .bus_error_o    (bus_error_o),
    .dbg_state_o    (dbg_state_o),
    .dbg_cnt_o      (dbg_cnt_o)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_m(input logic rw, input logic mw, input logic mtr,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd);
    reg_write_m_i  = rw;
    mem_write_m_i  = mw;
    mem_to_reg_m_i = mtr;
    alu_out_m_i    = alu;
    write_data_m_i = wd;
    write_reg_m_i  = rd;
  endtask

  task automatic bubble_m();
    drive_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b0;
    bubble_m();
    tick();
    tick();
    total_cnt++;
    if ({result_w_o, reg_write_w_o, bus_error_o, mem_req_o, stall_m_o} !== 36'd0)
      $display("FAIL reset_outputs: got result=%h rw=%b err=%b req=%b stall=%b, expected all 0",
               result_w_o, reg_write_w_o, bus_error_o, mem_req_o, stall_m_o);
    else pass_cnt++;
    rst_i = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (mem_req_o !== 1'b0)
      $display("FAIL bubble_req: got %b expected 0", mem_req_o);
    else pass_cnt++;
    total_cnt++;
    if ({alu_out_w_o, read_data_w_o, write_reg_w_o, reg_write_w_o} !== 70'd0)
      $display("FAIL bubble_w: got alu=%h rd=%h wr=%0d rw=%b expected all 0",
               alu_out_w_o, read_data_w_o, write_reg_w_o, reg_write_w_o);
    else pass_cnt++;
  endtask

  task automatic test_zero_wait_load();
    drive_m(1'b1, 1'b0, 1'b1, 32'h40, 32'd0, 5'd5);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    total_cnt++;
    if ({mem_req_o, mem_we_o, stall_m_o, mem_addr_o} !== {3'b100, 32'h40})
      $display("FAIL zw_request: got req=%b we=%b stall=%b addr=%h expected 1 0 0 00000040",
               mem_req_o, mem_we_o, stall_m_o, mem_addr_o);
    else pass_cnt++;
    tick();
    bubble_m();
    total_cnt++;
    if ({reg_write_w_o, write_reg_w_o, result_w_o} !== {1'b1, 5'd5, 32'h1234_5678})
      $display("FAIL zw_writeback: got rw=%b rd=%0d result=%h expected 1 5 12345678",
               reg_write_w_o, write_reg_w_o, result_w_o);
    else pass_cnt++;
  endtask

  task automatic test_store_3wait();
    drive_m(1'b0, 1'b1, 1'b0, 32'h80, 32'hCAFE_F00D, 5'd0);
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      total_cnt++;
      if ({stall_m_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !==
          {3'b111, 32'h80, 32'hCAFE_F00D})
        $display("FAIL st_stall_%0d: got stall=%b req=%b we=%b addr=%h wdata=%h expected 1 1 1 00000080 cafef00d",
                 i, stall_m_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({reg_write_w_o, alu_out_w_o, write_reg_w_o} !== 38'd0)
        $display("FAIL st_bubble_%0d: got rw=%b alu=%h rd=%0d expected 0 0 0",
                 i, reg_write_w_o, alu_out_w_o, write_reg_w_o);
      else pass_cnt++;
    end
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    total_cnt++;
    if ({stall_m_o, mem_req_o} !== 2'b01)
      $display("FAIL st_ready_cycle: got stall=%b req=%b expected 0 1", stall_m_o, mem_req_o);
    else pass_cnt++;
    tick();
    bubble_m();
    total_cnt++;
    if ({reg_write_w_o, alu_out_w_o, read_data_w_o} !== {1'b0, 32'h80, 32'd0})
      $display("FAIL st_writeback: got rw=%b alu=%h rdata=%h expected 0 00000080 00000000",
               reg_write_w_o, alu_out_w_o, read_data_w_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive_m(1'b1, 1'b0, 1'b1, 32'h100, 32'd0, 5'd3);
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0BAD_CAFE;
    tick();
    tick();
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hA5A5_0001;
    @(negedge clk_i);
    total_cnt++;
    if (stall_m_o !== 1'b0)
      $display("FAIL b2b_ready_stall: got %b expected 0", stall_m_o);
    else pass_cnt++;
    tick();
    drive_m(1'b1, 1'b0, 1'b0, 32'h99, 32'd0, 5'd7);
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'd0;
    total_cnt++;
    if ({reg_write_w_o, write_reg_w_o, result_w_o} !== {1'b1, 5'd3, 32'hA5A5_0001})
      $display("FAIL b2b_load_w: got rw=%b rd=%0d result=%h expected 1 3 a5a50001",
               reg_write_w_o, write_reg_w_o, result_w_o);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if ({mem_req_o, stall_m_o} !== 2'b00)
      $display("FAIL b2b_alu_req: got req=%b stall=%b expected 0 0", mem_req_o, stall_m_o);
    else pass_cnt++;
    tick();
    bubble_m();
    total_cnt++;
    if ({reg_write_w_o, mem_to_reg_w_o, write_reg_w_o, result_w_o} !== {2'b10, 5'd7, 32'h99})
      $display("FAIL b2b_alu_w: got rw=%b mtr=%b rd=%0d result=%h expected 1 0 7 00000099",
               reg_write_w_o, mem_to_reg_w_o, write_reg_w_o, result_w_o);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    drive_m(1'b1, 1'b0, 1'b1, 32'h200, 32'd0, 5'd9);
    mem_ready_i = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (stall_m_o) begin
        n++;
        tick();
      end else begin
        break;
      end
    end
    total_cnt++;
    if (n !== 4)
      $display("FAIL to_stall_cycles: got %0d expected 4", n);
    else pass_cnt++;
    total_cnt++;
    if ({mem_req_o, stall_m_o, bus_error_o} !== 3'b000)
      $display("FAIL to_abandon_cycle: got req=%b stall=%b err=%b expected 0 0 0",
               mem_req_o, stall_m_o, bus_error_o);
    else pass_cnt++;
    tick();
    bubble_m();
    total_cnt++;
    if ({read_data_w_o, reg_write_w_o, mem_to_reg_w_o, bus_error_o} !== {32'hDEAD_BEEF, 3'b011})
      $display("FAIL to_writeback: got rdata=%h rw=%b mtr=%b err=%b expected deadbeef 0 1 1",
               read_data_w_o, reg_write_w_o, mem_to_reg_w_o, bus_error_o);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (bus_error_o !== 1'b1)
      $display("FAIL to_sticky: got %b expected 1", bus_error_o);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    drive_m(1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 5'd4);
    tick();
    bubble_m();
    #2;
    rst_i = 1'b0;
    #1;
    total_cnt++;
    if ({result_w_o, reg_write_w_o, write_reg_w_o, bus_error_o} !== 39'd0)
      $display("FAIL async_reset: got result=%h rw=%b rd=%0d err=%b expected all 0",
               result_w_o, reg_write_w_o, write_reg_w_o, bus_error_o);
    else pass_cnt++;
    tick();
    rst_i = 1'b1;
  endtask

  task automatic test_misaligned();
    drive_m(1'b1, 1'b0, 1'b1, 32'h42, 32'd0, 5'd6);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h1111_1111;
    @(negedge clk_i);
    total_cnt++;
    if ({mem_req_o, stall_m_o, bus_error_o} !== 3'b000)
      $display("FAIL mis_request: got req=%b stall=%b err=%b expected 0 0 0",
               mem_req_o, stall_m_o, bus_error_o);
    else pass_cnt++;
    tick();
    bubble_m();
    total_cnt++;
    if ({bus_error_o, reg_write_w_o, write_reg_w_o, read_data_w_o} !== {2'b10, 5'd6, 32'd0})
      $display("FAIL mis_writeback: got err=%b rw=%b rd=%0d rdata=%h expected 1 0 6 00000000",
               bus_error_o, reg_write_w_o, write_reg_w_o, read_data_w_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    int n;
    drive_m(1'b0, 1'b1, 1'b0, 32'h300, 32'h7777_0000, 5'd0);
    mem_ready_i = 1'b0;
    tick();
    tick();
    bubble_m();
    #2;
    rst_i = 1'b0;
    #1;
    total_cnt++;
    if ({dbg_state_o, dbg_cnt_o, stall_m_o} !== 10'd0)
      $display("FAIL rw_reset_idle: got state=%b cnt=%0d stall=%b expected 0 0 0",
               dbg_state_o, dbg_cnt_o, stall_m_o);
    else pass_cnt++;
    tick();
    rst_i = 1'b1;
    drive_m(1'b1, 1'b0, 1'b1, 32'h400, 32'd0, 5'd2);
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if (stall_m_o !== 1'b1)
      $display("FAIL rw_restart_stall: got %b expected 1", stall_m_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({dbg_state_o, dbg_cnt_o} !== {1'b1, 8'd1})
      $display("FAIL rw_restart_cnt: got state=%b cnt=%0d expected 1 1", dbg_state_o, dbg_cnt_o);
    else pass_cnt++;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (stall_m_o) begin
        n++;
        tick();
      end else begin
        break;
      end
    end
    total_cnt++;
    if (n !== 4)
      $display("FAIL rw_full_timeout: got %0d stall cycles expected 4", n);
    else pass_cnt++;
    tick();
    bubble_m();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst_i = 1'b0;
    bubble_m();
    test_reset();
    test_zero_wait_load();
    test_store_3wait();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_misaligned();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
